// File: rtl/audio_sample_cacher_if.sv
// Sample input and RAM write bus of the audio sample cacher.
// The master modport is the cacher's view; the slave modport is the environment's view.
interface audio_sample_cacher_if #(
  parameter int bw_dpram = 12,
  parameter int bw_data  = 16
);
  logic [bw_data-1:0]  DataL;
  logic [bw_data-1:0]  DataR;
  logic                SampleValid;
  logic [bw_dpram-1:0] RAM_WAddr;
  logic [bw_data-1:0]  RAM_D;
  logic                RAM_WE;

  modport master (
    input  DataL, DataR, SampleValid,
    output RAM_WAddr, RAM_D, RAM_WE
  );

  modport slave (
    output DataL, DataR, SampleValid,
    input  RAM_WAddr, RAM_D, RAM_WE
  );
endinterface

// File: rtl/audio_sample_cacher.sv
// Captures stereo samples into one frame of the dual-port sample RAM (L low half, R high half),
// then holds the frame until Release. Optional 2:1 decimation: define CACHER_DECIM2_EN.
module audio_sample_cacher #(
  parameter int bw_dpram = 12,
  parameter int bw_data  = 16,
  parameter int bw_ovr   = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  audio_sample_cacher_if.master bus,
  input  logic                  Release,
  output logic                  StartLoader,
  output logic                  FrameReady,
  output logic [bw_ovr-1:0]     Overrun,
  output logic                  SpacingErr
);
  localparam int bw_idx = bw_dpram - 1;
  localparam logic [bw_idx-1:0] idx_last = {bw_idx{1'b1}};
  localparam logic [bw_ovr-1:0] ovr_max  = {bw_ovr{1'b1}};

  typedef enum logic [1:0] {
    FILL = 2'd0,
    WR_R = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t              state_r, state_s;
  logic [bw_idx-1:0]   idx_r, idx_s;
  logic [bw_data-1:0]  hold_r, hold_s;
  logic [bw_dpram-1:0] waddr_r, waddr_s;
  logic [bw_data-1:0]  wdata_r, wdata_s;
  logic                we_r, we_s;
  logic                start_r, start_s;
  logic                ready_r, ready_s;
  logic [bw_ovr-1:0]   ovr_r, ovr_s;
  logic                spc_r, spc_s;

`ifdef CACHER_DECIM2_EN
  logic                phase_r, phase_s;
  logic [bw_data-1:0]  prev_l_r, prev_l_s;
  logic [bw_data-1:0]  prev_r_r, prev_r_s;

  // Mean of two signed samples; the sum needs one guard bit before the arithmetic shift.
  function automatic logic [bw_data-1:0] avg2(input logic [bw_data-1:0] a,
                                              input logic [bw_data-1:0] b);
    logic [bw_data:0] sum;
    sum = {a[bw_data-1], a} + {b[bw_data-1], b};
    return sum[bw_data:1];
  endfunction
`endif

  // Next-state and next-output decode for the fill / write-right / full sequence.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    hold_s  = hold_r;
    waddr_s = waddr_r;
    wdata_s = wdata_r;
    we_s    = 1'b0;
    start_s = 1'b0;
    ready_s = ready_r;
    ovr_s   = ovr_r;
    spc_s   = spc_r;
`ifdef CACHER_DECIM2_EN
    phase_s  = phase_r;
    prev_l_s = prev_l_r;
    prev_r_s = prev_r_r;
`endif
    case (state_r)
      FILL: begin
        if (bus.SampleValid) begin
`ifdef CACHER_DECIM2_EN
          if (!phase_r) begin
            prev_l_s = bus.DataL;
            prev_r_s = bus.DataR;
            phase_s  = 1'b1;
          end else begin
            we_s    = 1'b1;
            waddr_s = {1'b0, idx_r};
            wdata_s = avg2(prev_l_r, bus.DataL);
            hold_s  = avg2(prev_r_r, bus.DataR);
            phase_s = 1'b0;
            state_s = WR_R;
          end
`else
          we_s    = 1'b1;
          waddr_s = {1'b0, idx_r};
          wdata_s = bus.DataL;
          hold_s  = bus.DataR;
          state_s = WR_R;
`endif
        end else begin
          state_s = FILL;
        end
      end
      WR_R: begin
        we_s    = 1'b1;
        waddr_s = {1'b1, idx_r};
        wdata_s = hold_r;
        // A strobe landing here would collide with the right-channel write, so it is lost.
        if (bus.SampleValid) begin
          spc_s = 1'b1;
        end else begin
          spc_s = spc_r;
        end
        if (idx_r == idx_last) begin
          idx_s   = {bw_idx{1'b0}};
          start_s = 1'b1;
          ready_s = 1'b1;
          state_s = FULL;
        end else begin
          idx_s   = idx_r + {{(bw_idx-1){1'b0}}, 1'b1};
          state_s = FILL;
        end
      end
      FULL: begin
        if (bus.SampleValid && (ovr_r != ovr_max)) begin
          ovr_s = ovr_r + {{(bw_ovr-1){1'b0}}, 1'b1};
        end else begin
          ovr_s = ovr_r;
        end
        if (Release) begin
          ready_s = 1'b0;
          idx_s   = {bw_idx{1'b0}};
          state_s = FILL;
`ifdef CACHER_DECIM2_EN
          phase_s = 1'b0;
`endif
        end else begin
          state_s = FULL;
        end
      end
      default: begin
        state_s = FILL;
        idx_s   = {bw_idx{1'b0}};
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r <= FILL;
      idx_r   <= {bw_idx{1'b0}};
      hold_r  <= {bw_data{1'b0}};
      waddr_r <= {bw_dpram{1'b0}};
      wdata_r <= {bw_data{1'b0}};
      we_r    <= 1'b0;
      start_r <= 1'b0;
      ready_r <= 1'b0;
      ovr_r   <= {bw_ovr{1'b0}};
      spc_r   <= 1'b0;
`ifdef CACHER_DECIM2_EN
      phase_r  <= 1'b0;
      prev_l_r <= {bw_data{1'b0}};
      prev_r_r <= {bw_data{1'b0}};
`endif
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      hold_r  <= hold_s;
      waddr_r <= waddr_s;
      wdata_r <= wdata_s;
      we_r    <= we_s;
      start_r <= start_s;
      ready_r <= ready_s;
      ovr_r   <= ovr_s;
      spc_r   <= spc_s;
`ifdef CACHER_DECIM2_EN
      phase_r  <= phase_s;
      prev_l_r <= prev_l_s;
      prev_r_r <= prev_r_s;
`endif
    end
  end

  assign bus.RAM_WAddr = waddr_r;
  assign bus.RAM_D     = wdata_r;
  assign bus.RAM_WE    = we_r;
  assign StartLoader   = start_r;
  assign FrameReady    = ready_r;
  assign Overrun       = ovr_r;
  assign SpacingErr    = spc_r;
endmodule

// File: tb/tb_audio_sample_cacher.sv
// Bench for audio_sample_cacher (N=8, 3-bit overrun): frame-level scoreboard model checked
// every cycle, plus directed checks of RAM contents and counters.
module tb_audio_sample_cacher;
  localparam int N       = 8;
  localparam int OVR_MAX = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rel = 1'b0;
  logic start_loader, frame_ready, spacing_err;
  logic [2:0] overrun;

  audio_sample_cacher_if #(.bw_dpram(4), .bw_data(16)) bus_if ();

  audio_sample_cacher #(.bw_dpram(4), .bw_data(16), .bw_ovr(3)) dut (
    .Clock      (clk),
    .Reset      (rst),
    .bus        (bus_if.master),
    .Release    (rel),
    .StartLoader(start_loader),
    .FrameReady (frame_ready),
    .Overrun    (overrun),
    .SpacingErr (spacing_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Frame-level model: expected RAM writes as (cycle, address, data) events, plus flags.
  typedef struct {
    int          c;
    logic [3:0]  a;
    logic [15:0] d;
  } wr_t;
  wr_t q[$];
  wr_t ev;

  int   cyc = 0;
  int   busy_edge = -1;
  int   n_acc = 0;
  bit   m_full = 1'b0;
  bit   fr_on = 1'b0;
  int   fr_from = 0;
  int   start_cyc = -1;
  int   m_ovr = 0;
  bit   m_spc = 1'b0;
  logic [15:0] wl, wr;
  bit   do_w;
`ifdef CACHER_DECIM2_EN
  bit   ph = 1'b0;
  logic [15:0] pl, pr;

  function automatic logic [15:0] mavg(input logic [15:0] a, input logic [15:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
    return 16'(s >>> 1);
  endfunction
`endif

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      q.delete();
      busy_edge = -1; n_acc = 0; m_full = 1'b0; fr_on = 1'b0; start_cyc = -1;
      m_ovr = 0; m_spc = 1'b0;
`ifdef CACHER_DECIM2_EN
      ph = 1'b0;
`endif
    end else if (cyc == busy_edge) begin
      if (bus_if.SampleValid) m_spc = 1'b1;
    end else if (m_full) begin
      if (bus_if.SampleValid && m_ovr < OVR_MAX) m_ovr++;
      if (rel) begin
        m_full = 1'b0;
        fr_on  = 1'b0;
`ifdef CACHER_DECIM2_EN
        ph = 1'b0;
`endif
      end
    end else if (bus_if.SampleValid) begin
      wl = bus_if.DataL; wr = bus_if.DataR; do_w = 1'b1;
`ifdef CACHER_DECIM2_EN
      if (!ph) begin
        pl = bus_if.DataL; pr = bus_if.DataR; do_w = 1'b0;
      end else begin
        wl = mavg(pl, bus_if.DataL); wr = mavg(pr, bus_if.DataR);
      end
      ph = !ph;
`endif
      if (do_w) begin
        ev.c = cyc;     ev.a = 4'(n_acc);     ev.d = wl; q.push_back(ev);
        ev.c = cyc + 1; ev.a = 4'(N + n_acc); ev.d = wr; q.push_back(ev);
        busy_edge = cyc + 1;
        n_acc++;
        if (n_acc == N) begin
          n_acc = 0; m_full = 1'b1; fr_on = 1'b1; fr_from = cyc + 1; start_cyc = cyc + 1;
        end
      end
    end
  end

  logic [15:0] ram [16];
  logic [3:0]  last_l = 4'd0;
  int          n_start = 0;

  // Per-cycle comparison of every DUT output against the model; also records RAM writes.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      if (q.size() > 0 && q[0].c == cyc) begin
        check("ram_we", 32'(bus_if.RAM_WE), 32'd1);
        check("ram_waddr", 32'(bus_if.RAM_WAddr), 32'(q[0].a));
        check("ram_d", 32'(bus_if.RAM_D), 32'(q[0].d));
        void'(q.pop_front());
      end else begin
        check("ram_we_idle", 32'(bus_if.RAM_WE), 32'd0);
      end
      check("start_loader", 32'(start_loader), 32'(cyc == start_cyc));
      check("frame_ready", 32'(frame_ready), 32'(fr_on && cyc >= fr_from));
      check("overrun", 32'(overrun), 32'(m_ovr));
      check("spacing_err", 32'(spacing_err), 32'(m_spc));
      if (bus_if.RAM_WE) begin
        ram[bus_if.RAM_WAddr] = bus_if.RAM_D;
        if (!bus_if.RAM_WAddr[3]) last_l = bus_if.RAM_WAddr;
      end
      if (start_loader) n_start++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [15:0] l, input logic [15:0] r, input int gap);
    bus_if.SampleValid = 1'b1;
    bus_if.DataL = l;
    bus_if.DataR = r;
    tick();
    bus_if.SampleValid = 1'b0;
    repeat (gap) tick();
  endtask

  // One stored sample; with decimation each value is sent twice so its average is itself.
  task automatic sample(input logic [15:0] l, input logic [15:0] r, input int gap);
`ifdef CACHER_DECIM2_EN
    strobe(l, r, 2);
`endif
    strobe(l, r, gap);
  endtask

  task automatic release_frame();
    rel = 1'b1;
    tick();
    rel = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"}, 32'(bus_if.RAM_WE), 32'd0);
    check({tag, "_waddr"}, 32'(bus_if.RAM_WAddr), 32'd0);
    check({tag, "_d"}, 32'(bus_if.RAM_D), 32'd0);
    check({tag, "_start"}, 32'(start_loader), 32'd0);
    check({tag, "_ready"}, 32'(frame_ready), 32'd0);
    check({tag, "_ovr"}, 32'(overrun), 32'd0);
    check({tag, "_spc"}, 32'(spacing_err), 32'd0);
  endtask

  initial begin
    bus_if.SampleValid = 1'b0;
    bus_if.DataL = 16'h0000;
    bus_if.DataR = 16'h0000;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;

    // Full frame: L=k, R=0x100+k.
    for (int k = 0; k < N; k++) sample(16'(k), 16'(16'h0100 + k), 3);
    repeat (3) tick();
    for (int k = 0; k < N; k++) begin
      check("frame1_left", 32'(ram[k]), 32'(k));
      check("frame1_right", 32'(ram[N + k]), 32'(16'h0100 + k));
    end
    check("frame1_starts", 32'(n_start), 32'd1);
    check("frame1_ready", 32'(frame_ready), 32'd1);

    // Drops while full, then release and restart at address 0.
    for (int k = 0; k < 5; k++) strobe(16'hDEAD, 16'hBEEF, 2);
    check("overrun_5", 32'(overrun), 32'd5);
    release_frame();
    check("released_ready", 32'(frame_ready), 32'd0);
    sample(16'hAAAA, 16'h5555, 3);
    check("restart_left0", 32'(ram[0]), 32'h0000_AAAA);
    check("restart_right0", 32'(ram[8]), 32'h0000_5555);
    for (int k = 1; k < N; k++) sample(16'(16'h0040 + k), 16'(16'h0080 + k), 3);
    repeat (3) tick();
    check("frame2_starts", 32'(n_start), 32'd2);

    // Overrun saturates.
    for (int k = 0; k < 10; k++) strobe(16'h1234, 16'h5678, 1);
    check("overrun_sat", 32'(overrun), 32'd7);

    // Release together with a strobe: sample dropped and counted (already saturated).
    rel = 1'b1;
    strobe(16'hCAFE, 16'hF00D, 2);
    rel = 1'b0;
    check("rel_strobe_ready", 32'(frame_ready), 32'd0);

    // Back-to-back strobes: second one lost, index advances once.
    sample(16'h1111, 16'h2222, 0);
    strobe(16'h3333, 16'h4444, 3);
    check("spacing_set", 32'(spacing_err), 32'd1);
    check("spacing_left0", 32'(ram[0]), 32'h0000_1111);
    sample(16'h5555, 16'h6666, 3);
    check("spacing_next_addr", 32'(last_l), 32'd1);
    check("spacing_left1", 32'(ram[1]), 32'h0000_5555);
    check("spacing_right1", 32'(ram[9]), 32'h0000_6666);

    // Reset after three samples of the frame.
    sample(16'h7777, 16'h8888, 3);
    rst = 1'b1;
    repeat (2) tick();
    check_all_zero("midreset");
    rst = 1'b0;
    for (int k = 0; k < N; k++) sample(16'(16'h0200 + k), 16'(16'h0300 + k), 3);
    repeat (3) tick();
    for (int k = 0; k < N; k++) begin
      check("frame3_left", 32'(ram[k]), 32'(16'h0200 + k));
      check("frame3_right", 32'(ram[N + k]), 32'(16'h0300 + k));
    end
    check("frame3_starts", 32'(n_start), 32'd3);

`ifdef CACHER_DECIM2_EN
    release_frame();
    strobe(16'h7FFE, 16'h0000, 2);
    strobe(16'h7FFF, 16'h0000, 2);
    strobe(16'h8000, 16'h0000, 2);
    strobe(16'h8002, 16'h0000, 3);
    check("decim_pos", 32'(ram[0]), 32'h0000_7FFE);
    check("decim_neg", 32'(ram[1]), 32'h0000_8001);
`endif

    repeat (4) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
